// File: rtl/cpu_core_p_if.sv
// Bus between cpu_core_p and its instruction memory / observer.
// The core drives PC and status flags; the memory side returns INSTRUCTION and BUSYWAIT.
interface cpu_core_p_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 32
);
    logic [31:0]       INSTRUCTION;
    logic              BUSYWAIT;
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] ALU_RESULT;
    logic              ZERO;
    logic              ILLEGAL;

    modport master (
        input  INSTRUCTION, BUSYWAIT,
        output PC, ALU_RESULT, ZERO, ILLEGAL
    );

    modport slave (
        output INSTRUCTION, BUSYWAIT,
        input  PC, ALU_RESULT, ZERO, ILLEGAL
    );
endinterface

// File: rtl/cpu_core_p.sv
// Parametrised single-cycle CPU core: PC, register file, ALU and decode.
// One instruction retires per unstalled clock; ALU and flags are purely combinational.
module cpu_core_p #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32
) (
    input logic          CLK,
    input logic          RESET,
    cpu_core_p_if.master bus
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    typedef enum logic [7:0] {
        OP_LOADI = 8'h00,
        OP_MOV   = 8'h01,
        OP_ADD   = 8'h02,
        OP_SUB   = 8'h03,
        OP_AND   = 8'h04,
        OP_OR    = 8'h05,
        OP_J     = 8'h06,
        OP_BEQ   = 8'h07
    } opcode_e;

    logic [7:0]              opcode;
    logic [REG_ADDR_W-1:0]   dest, src1, src2;
    logic [DATA_W-1:0]       imm, rd1, rd2, result;
    logic signed [PC_W-1:0]  offset_sh;
    logic [PC_W-1:0]         pc_q, pc_plus4, pc_next;
    logic                    reg_we, taken, zero;
    logic                    unused_instr_bits;
    logic [DATA_W-1:0]       regs [NREGS];

    // Subtraction is two's-complement add so sub and beq share one path.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [7:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] k
    );
        logic [DATA_W-1:0] neg_b;
        neg_b = ~b + 1'b1;
        case (op)
            OP_LOADI:              alu_f = k;
            OP_MOV:                alu_f = b;
            OP_ADD:                alu_f = a + b;
            OP_SUB, OP_J, OP_BEQ:  alu_f = a + neg_b;
            OP_AND:                alu_f = a & b;
            OP_OR:                 alu_f = a | b;
            default:               alu_f = '0;
        endcase
    endfunction

    assign opcode = bus.INSTRUCTION[31:24];
    assign dest   = bus.INSTRUCTION[16 +: REG_ADDR_W];
    assign src1   = bus.INSTRUCTION[8 +: REG_ADDR_W];
    assign src2   = bus.INSTRUCTION[0 +: REG_ADDR_W];
    assign imm    = DATA_W'(bus.INSTRUCTION[7:0]);
    assign unused_instr_bits = ^bus.INSTRUCTION;

    // Branch offset counts instructions, so scale by 4 after sign extension.
    assign offset_sh = {{(PC_W-10){bus.INSTRUCTION[23]}}, bus.INSTRUCTION[23:16], 2'b00};

    assign rd1    = regs[src1];
    assign rd2    = regs[src2];
    assign result = alu_f(opcode, rd1, rd2, imm);
    assign zero   = (result == '0);

    assign taken    = (opcode == OP_J) || ((opcode == OP_BEQ) && zero);
    assign pc_plus4 = pc_q + PC_W'(4);
    assign pc_next  = taken ? (pc_plus4 + offset_sh) : pc_plus4;
    assign reg_we   = (opcode <= OP_OR) && !bus.BUSYWAIT && !RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q <= '0;
        end else if (!bus.BUSYWAIT) begin
            pc_q <= pc_next;
        end
    end

    // Reads above see the pre-edge contents, giving write-then-read-next-cycle semantics.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[dest] <= result;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.ALU_RESULT = result;
    assign bus.ZERO       = zero;
    assign bus.ILLEGAL    = (opcode > OP_BEQ) && !bus.BUSYWAIT;
endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p: an 8-bit/8-reg core and a 16-bit/16-reg core run the
// same instruction stream against an arithmetic reference model.
module tb_cpu_core_p;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] instr = '0;
    logic        busy = 1'b0;

    always #5 CLK = ~CLK;

    cpu_core_p_if #(.DATA_W(8),  .PC_W(32)) bus8 ();
    cpu_core_p_if #(.DATA_W(16), .PC_W(32)) bus16 ();

    assign bus8.INSTRUCTION  = instr;
    assign bus8.BUSYWAIT     = busy;
    assign bus16.INSTRUCTION = instr;
    assign bus16.BUSYWAIT    = busy;

    cpu_core_p #(.DATA_W(8),  .REG_ADDR_W(3), .PC_W(32)) dut8  (.CLK(CLK), .RESET(RESET), .bus(bus8));
    cpu_core_p #(.DATA_W(16), .REG_ADDR_W(4), .PC_W(32)) dut16 (.CLK(CLK), .RESET(RESET), .bus(bus16));

    typedef struct {
        int          d;
        string       nm;
        bit          cp;
        bit          ca;
        bit          ci;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mreg [2][16];
    logic [31:0] mpc  [2];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    endfunction

    // Reference model: architectural state per core, updated by the instruction rules.
    task automatic model(input int d, input logic [31:0] ins, input logic bw, input logic rs, input string nm);
        logic [31:0] dm, a, b, res;
        int am, op, dst, s1, s2, off;
        exp_t e;
        dm = (d == 1) ? 32'hFFFF : 32'hFF;
        am = (d == 1) ? 15 : 7;
        if (rs) begin
            for (int i = 0; i < 16; i++) mreg[d][i] = '0;
            mpc[d] = '0;
        end
        op  = int'(ins[31:24]);
        dst = int'(ins[23:16]) & am;
        s1  = int'(ins[15:8]) & am;
        s2  = int'(ins[7:0]) & am;
        off = int'($signed(ins[23:16]));
        a = mreg[d][s1];
        b = mreg[d][s2];
        case (op)
            0:       res = {24'h0, ins[7:0]};
            1:       res = b;
            2:       res = a + b;
            3, 7:    res = a - b;
            4:       res = a & b;
            5:       res = a | b;
            default: res = '0;
        endcase
        res = res & dm;
        e.d = d; e.nm = nm; e.cp = 1'b1; e.ci = 1'b1;
        e.ca = (op <= 5) || (op == 7);
        e.pc = mpc[d]; e.alu = res; e.zero = (res == 0);
        e.ill = (op > 7) && !bw;
        sbq.push_back(e);
        if (!rs && !bw) begin
            if (op <= 5) mreg[d][dst] = res;
            if (op == 6 || (op == 7 && res == 0)) mpc[d] = mpc[d] + 32'(4 + off * 4);
            else mpc[d] = mpc[d] + 32'd4;
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic bw, input logic rs, input string nm);
        @(posedge CLK);
        #1;
        RESET = rs;
        instr = ins;
        busy  = bw;
        model(0, ins, bw, rs, nm);
        model(1, ins, bw, rs, nm);
    endtask

    // Hand-derived expectation for the cycle just issued.
    task automatic cexp(input int d, input string nm, input bit cp, input logic [31:0] pcv,
                        input bit ca, input logic [31:0] alv);
        exp_t e;
        e.d = d; e.nm = nm; e.cp = cp; e.ca = ca; e.ci = 1'b0;
        e.pc = pcv; e.alu = alv; e.zero = (alv == 0); e.ill = 1'b0;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] enc_r(input int op, input int dst, input int s1, input int s2);
        return {op[7:0], dst[7:0], s1[7:0], s2[7:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int dst, input int imm);
        return {8'h00, dst[7:0], 8'h00, imm[7:0]};
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t        e;
        logic [31:0] apc, aal;
        logic        az, ai;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.d == 0) begin
                apc = bus8.PC; aal = 32'(bus8.ALU_RESULT); az = bus8.ZERO; ai = bus8.ILLEGAL;
            end else begin
                apc = bus16.PC; aal = 32'(bus16.ALU_RESULT); az = bus16.ZERO; ai = bus16.ILLEGAL;
            end
            if (e.cp) chk($sformatf("%s[d%0d].pc", e.nm, e.d), apc, e.pc);
            if (e.ca) begin
                chk($sformatf("%s[d%0d].alu", e.nm, e.d), aal, e.alu);
                chk($sformatf("%s[d%0d].zero", e.nm, e.d), 32'(az), 32'(e.zero));
            end
            if (e.ci) chk($sformatf("%s[d%0d].illegal", e.nm, e.d), 32'(ai), 32'(e.ill));
        end
    end

    task automatic arith(input int b);
        step(enc_i(b, 11), 0, 0, "ld_a");
        step(enc_i(b + 1, 3), 0, 0, "ld_b");
        step(enc_r(3, b + 2, b, b + 1), 0, 0, "sub");
        step(enc_r(2, b + 3, b, b + 1), 0, 0, "add");
        step(enc_r(4, b + 4, b, b + 1), 0, 0, "and");
        step(enc_r(5, b + 5, b, b + 1), 0, 0, "or");
        step(enc_r(1, b + 6, 0, b + 1), 0, 0, "mov");
        step(enc_r(1, b + 7, 0, b + 2), 0, 0, "rd_sub");
        for (int d = 0; d < 2; d++) cexp(d, "k_sub", 0, 0, 1, 8);
        step(enc_r(1, b + 7, 0, b + 3), 0, 0, "rd_add");
        for (int d = 0; d < 2; d++) cexp(d, "k_add", 0, 0, 1, 14);
        step(enc_r(1, b + 7, 0, b + 4), 0, 0, "rd_and");
        for (int d = 0; d < 2; d++) cexp(d, "k_and", 0, 0, 1, 3);
        step(enc_r(1, b + 7, 0, b + 5), 0, 0, "rd_or");
        for (int d = 0; d < 2; d++) cexp(d, "k_or", 0, 0, 1, 11);
        step(enc_r(1, b + 7, 0, b + 6), 0, 0, "rd_mov");
        for (int d = 0; d < 2; d++) cexp(d, "k_mov", 0, 0, 1, 3);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sbq.size());
        $fatal(1);
    end

    initial begin : stim
        for (int d = 0; d < 2; d++) begin
            mpc[d] = '0;
            for (int i = 0; i < 16; i++) mreg[d][i] = '0;
        end

        // Reset and defaults
        step(enc_i(0, 0), 0, 1, "rst0");
        for (int d = 0; d < 2; d++) cexp(d, "k_rst_pc", 1, 0, 0, 0);
        step(enc_i(0, 0), 0, 1, "rst1");
        for (int k = 0; k < 3; k++) step(enc_i(0, 0), 0, 0, "nop");
        step(enc_r(1, 7, 0, 0), 0, 0, "rd_r0");
        for (int d = 0; d < 2; d++) cexp(d, "k_pc12", 1, 12, 1, 0);
        for (int r = 1; r < 8; r++) begin
            step(enc_r(1, 7, 0, r), 0, 0, "rd_zero");
            for (int d = 0; d < 2; d++) cexp(d, "k_zero", 0, 0, 1, 0);
        end

        arith(0);

        // Wrap-around on sub and add
        step(enc_i(0, 3), 0, 0, "ld3");
        step(enc_i(1, 5), 0, 0, "ld5");
        step(enc_r(3, 2, 0, 1), 0, 0, "sub_wrap");
        cexp(0, "k_sub_wrap", 0, 0, 1, 32'hFE);
        cexp(1, "k_sub_wrap", 0, 0, 1, 32'hFFFE);
        step(enc_i(3, 255), 0, 0, "ldff");
        step(enc_r(2, 4, 3, 3), 0, 0, "add_wrap");
        cexp(0, "k_add_wrap", 0, 0, 1, 32'hFE);
        cexp(1, "k_add_wrap", 0, 0, 1, 32'h1FE);

        // Branch and jump
        step(enc_i(0, 0), 0, 1, "rst_b");
        step(enc_i(0, 0), 0, 0, "ld_r0");
        step(enc_i(1, 1), 0, 0, "ld_r1");
        step(enc_r(7, 2, 0, 0), 0, 0, "beq_taken");
        for (int d = 0; d < 2; d++) cexp(d, "k_beq_pc", 1, 8, 0, 0);
        step(enc_r(6, 8'hFE, 0, 0), 0, 0, "jmp_back");
        for (int d = 0; d < 2; d++) cexp(d, "k_j_pc", 1, 20, 0, 0);
        step(enc_r(7, 2, 0, 1), 0, 0, "beq_not");
        for (int d = 0; d < 2; d++) cexp(d, "k_beqn_pc", 1, 16, 0, 0);
        step(enc_r(1, 7, 0, 0), 0, 0, "rd_r0b");
        for (int d = 0; d < 2; d++) cexp(d, "k_after_beq", 1, 20, 1, 0);
        step(enc_r(1, 7, 0, 2), 0, 0, "rd_r2b");
        for (int d = 0; d < 2; d++) cexp(d, "k_no_wr", 1, 24, 1, 0);

        // Stall
        for (int k = 0; k < 3; k++) begin
            step(enc_r(2, 3, 0, 1), 1, 0, "stall");
            for (int d = 0; d < 2; d++) cexp(d, "k_stall_pc", 1, 28, 0, 0);
        end
        step(enc_r(2, 3, 0, 1), 0, 0, "stall_rel");
        step(enc_r(1, 7, 0, 3), 0, 0, "rd_r3");
        for (int d = 0; d < 2; d++) cexp(d, "k_stall_wr", 1, 32, 1, 1);

        // Illegal opcodes
        step(enc_r(9, 2, 0, 1), 0, 0, "illegal");
        step(enc_r(255, 2, 0, 1), 1, 0, "illegal_stall");
        step(enc_r(1, 7, 0, 2), 0, 0, "rd_r2i");
        for (int d = 0; d < 2; d++) cexp(d, "k_ill_nowr", 1, 40, 1, 0);

        // Asynchronous reset between edges
        @(posedge CLK);
        #1;
        instr = enc_r(1, 7, 0, 1);
        busy  = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst[d0].pc", bus8.PC, 32'h0);
        chk("async_rst[d1].pc", bus16.PC, 32'h0);
        chk("async_rst[d0].alu", 32'(bus8.ALU_RESULT), 32'h0);
        chk("async_rst[d1].alu", 32'(bus16.ALU_RESULT), 32'h0);
        step(enc_i(1, 5), 1, 1, "rst_in_stall");
        step(enc_i(1, 5), 0, 0, "first_after_rst");
        for (int d = 0; d < 2; d++) cexp(d, "k_first_pc", 1, 0, 1, 5);

        // Wide-core register range and 16-bit wrap
        arith(8);
        step(enc_i(8, 0), 0, 0, "ld_zero");
        step(enc_i(9, 1), 0, 0, "ld_one");
        step(enc_r(3, 10, 8, 9), 0, 0, "mk_max");
        cexp(0, "k_max", 0, 0, 1, 32'hFF);
        cexp(1, "k_max", 0, 0, 1, 32'hFFFF);
        step(enc_r(2, 11, 10, 9), 0, 0, "max_plus1");
        for (int d = 0; d < 2; d++) cexp(d, "k_max_plus1", 0, 0, 1, 0);

        // Randomized stream
        for (int n = 0; n < 500; n++) begin
            logic [31:0] ins;
            logic        bw, rs;
            ins = {8'($urandom_range(0, 9)), 24'($urandom)};
            bw  = ($urandom_range(0, 4) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            step(ins, bw, rs, "rand");
        end

        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("scoreboard_drain", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
